// File: rtl/mili_stopwatch.sv
// Millisecond stopwatch: divides clk into 1 ms ticks and accumulates elapsed time under start/stop/clear/lap.
// Latency: controls take effect on the next edge; outputs are registers or decodes of registers only.
// Backpressure: none; free-running. Optional day wrap via MILI_STOPWATCH_DAY_WRAP_EN adds dayRollover.
module mili_stopwatch #(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int MS_WIDTH    = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    input  logic                clear,
    input  logic                lap,
    output logic [MS_WIDTH-1:0] elapsedMili,
    output logic [MS_WIDTH-1:0] lapMili,
    output logic                lapValid,
    output logic                running,
`ifdef MILI_STOPWATCH_DAY_WRAP_EN
    output logic                dayRollover,
`endif
    output logic                tickMs
);

    localparam int DIV = CLK_FREQ_HZ / 1000;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [PW-1:0]       presc;
    logic [MS_WIDTH-1:0] elapsed;
    logic [MS_WIDTH-1:0] elapsed_inc;
    logic                tick;
    logic                lap_take;

    assign tick     = (state == RUN) && (presc == PW'(DIV - 1));
    assign lap_take = lap && (state != IDLE);

`ifdef MILI_STOPWATCH_DAY_WRAP_EN
    localparam logic [MS_WIDTH-1:0] DAY_LAST = MS_WIDTH'(86399999);
    logic day_end;
    assign day_end     = (elapsed == DAY_LAST);
    assign elapsed_inc = day_end ? '0 : elapsed + 1'b1;
    assign dayRollover = tick && day_end;
`else
    assign elapsed_inc = elapsed + 1'b1;
`endif

    // stop outranks start even where stop itself does nothing (IDLE/PAUSED)
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else if (stop) begin
            if (state == RUN) state_nxt = PAUSED;
        end else if (start && (state != RUN)) begin
            state_nxt = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc    <= '0;
            elapsed  <= '0;
            lapMili  <= '0;
            lapValid <= 1'b0;
        end else if (clear) begin
            presc    <= '0;
            elapsed  <= '0;
            lapMili  <= '0;
            lapValid <= 1'b0;
        end else begin
            lapValid <= lap_take;
            // snapshot sees the pre-increment value when a tick coincides
            if (lap_take) lapMili <= elapsed;
            if (state == RUN) begin
                if (tick) begin
                    presc   <= '0;
                    elapsed <= elapsed_inc;
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

    assign elapsedMili = elapsed;
    assign running     = (state == RUN);
    assign tickMs      = tick;

endmodule

// File: tb/tb_mili_stopwatch.sv
// Bench for mili_stopwatch at DIV=4: directed vector table, hand sequences, then random traffic vs a cycle-count model.
module tb_mili_stopwatch;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, stop = 1'b0, clear = 1'b0, lap = 1'b0;
    logic [63:0] elapsedMili, lapMili;
    logic        lapValid, running, tickMs;
    logic [3:0]  s_elapsed, s_lap;
    logic        s_lapv, s_run, s_tick;

    int vecs = 0;
    int errs = 0;

    // Model: elapsed time is the number of edges spent in RUN since the last clear, divided by DIV.
    int              m_mode;   // 0 idle, 1 run, 2 paused
    longint unsigned m_cyc;
    longint unsigned m_lap;
    bit              m_lapv;

    typedef struct {
        logic st, sp, cl, lp;
        longint unsigned el;
        logic run, tk, lv;
        longint unsigned lm;
    } vec_t;

    vec_t tbl[16];

    mili_stopwatch #(.CLK_FREQ_HZ(4000)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear), .lap(lap),
        .elapsedMili(elapsedMili), .lapMili(lapMili), .lapValid(lapValid),
        .running(running), .tickMs(tickMs)
    );

    mili_stopwatch #(.CLK_FREQ_HZ(4000), .MS_WIDTH(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear), .lap(lap),
        .elapsedMili(s_elapsed), .lapMili(s_lap), .lapValid(s_lapv),
        .running(s_run), .tickMs(s_tick)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_cyc = 0; m_lap = 0; m_lapv = 0;
    endtask

    task automatic model_edge(input logic st, sp, cl, lp);
        if (cl) begin
            model_reset();
        end else begin
            m_lapv = lp && (m_mode != 0);
            if (m_lapv) m_lap = m_cyc / DIV;
            if (m_mode == 1) m_cyc++;
            if (sp) begin
                if (m_mode == 1) m_mode = 2;
            end else if (st && m_mode != 1) begin
                m_mode = 1;
            end
        end
    endtask

    task automatic check_model();
        cmp("elapsed", elapsedMili, m_cyc / DIV);
        cmp("running", {63'd0, running}, {63'd0, m_mode == 1});
        cmp("tick", {63'd0, tickMs}, {63'd0, (m_mode == 1) && (m_cyc % DIV == DIV - 1)});
        cmp("lapMili", lapMili, m_lap);
        cmp("lapValid", {63'd0, lapValid}, {63'd0, m_lapv});
        cmp("small_elapsed", {60'd0, s_elapsed}, (m_cyc / DIV) % 16);
    endtask

    task automatic step(input logic st, sp, cl, lp);
        @(negedge clk);
        start = st; stop = sp; clear = cl; lap = lp;
        @(posedge clk);
        model_edge(st, sp, cl, lp);
        #1;
        check_model();
    endtask

    initial begin
        int ticks;
        //          st  sp  cl  lp  el run tk lv lm
        tbl[0]  = '{1, 0, 0, 0, 0, 1, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 0, 0, 1, 1, 0, 0};
        tbl[4]  = '{0, 0, 0, 0, 1, 1, 0, 0, 0};
        tbl[5]  = '{0, 0, 0, 1, 1, 1, 0, 1, 1};
        tbl[6]  = '{0, 0, 0, 0, 1, 1, 0, 0, 1};
        tbl[7]  = '{0, 1, 0, 0, 1, 0, 0, 0, 1};
        tbl[8]  = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
        tbl[9]  = '{0, 0, 0, 1, 1, 0, 0, 1, 1};
        tbl[10] = '{1, 0, 0, 0, 1, 1, 1, 0, 1};
        tbl[11] = '{0, 1, 0, 0, 2, 0, 0, 0, 1};
        tbl[12] = '{1, 1, 0, 0, 2, 0, 0, 0, 1};
        tbl[13] = '{1, 0, 1, 0, 0, 0, 0, 0, 0};
        tbl[14] = '{1, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[15] = '{0, 0, 0, 1, 0, 0, 0, 0, 0};

        model_reset();
        #2;
        cmp("reset_elapsed", elapsedMili, 0);
        cmp("reset_flags", {61'd0, running, tickMs, lapValid}, 0);
        cmp("reset_lap", lapMili, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0);

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].st, tbl[i].sp, tbl[i].cl, tbl[i].lp);
            cmp($sformatf("tbl%0d_el", i), elapsedMili, tbl[i].el);
            cmp($sformatf("tbl%0d_flags", i), {61'd0, running, tickMs, lapValid},
                {61'd0, tbl[i].run, tbl[i].tk, tbl[i].lv});
            cmp($sformatf("tbl%0d_lap", i), lapMili, tbl[i].lm);
        end

        // 40 cycles of RUN: ten ticks, elapsed 10
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        ticks = 0;
        for (int i = 0; i < 40; i++) begin
            step(0, 0, 0, 0);
            if (tickMs) ticks++;
        end
        cmp("run40_elapsed", elapsedMili, 10);
        cmp("run40_ticks", 64'(ticks), 10);

        // pause with prescaler at 2, resume: increment lands 2 cycles after running rises
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 19; i++) step(0, 1, 0, 0);
        cmp("paused_elapsed", elapsedMili, 1);
        step(1, 0, 0, 0);
        cmp("resume_c0", elapsedMili, 1);
        step(0, 0, 0, 0);
        cmp("resume_c1", elapsedMili, 1);
        step(0, 0, 0, 0);
        cmp("resume_c2", elapsedMili, 2);

        // asynchronous reset in the middle of a cycle while running
        step(0, 0, 0, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        cmp("arst_elapsed", elapsedMili, 0);
        cmp("arst_flags", {61'd0, running, tickMs, lapValid}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0);

        // narrow instance wraps modulo 2^4
        step(1, 0, 0, 0);
        for (int i = 0; i < 64; i++) step(0, 0, 0, 0);
        cmp("wrap_small", {60'd0, s_elapsed}, 0);
        cmp("wrap_wide", elapsedMili, 16);

        for (int i = 0; i < 800; i++) begin
            step($urandom % 4 == 0, $urandom % 7 == 0, $urandom % 50 == 0, $urandom % 5 == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/mili_stopwatch.md
Name: mili_stopwatch

Overview:
Millisecond-resolution stopwatch that sits directly upstream of the ms-to-H/M/S/ms converter and drives its 64-bit millisecond input. It divides the system clock into 1 ms ticks and accumulates elapsed time under start/stop/clear/lap control. It also holds a lap snapshot, which can be muxed into the converter.

Parameters:
CLK_FREQ_HZ, 100000000, system clock frequency. DIV = CLK_FREQ_HZ/1000 must be an integer and at least 2.
MS_WIDTH, 64, width of the elapsed and lap millisecond counters; matches the converter input.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  level-sampled; begin or resume counting
stop  input  1  level-sampled; pause counting
clear  input  1  level-sampled; zero all counts and return to IDLE
lap  input  1  level-sampled; capture a lap snapshot
elapsedMili  output  MS_WIDTH  running millisecond total; feeds the converter
lapMili  output  MS_WIDTH  last captured snapshot
lapValid  output  1  one-cycle pulse when lapMili updates
running  output  1  high while in RUN
tickMs  output  1  one-cycle pulse on each counted millisecond

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE. elapsedMili=0, lapMili=0, prescaler=0. lapValid, running and tickMs are all 0.
- States:
  - IDLE: counters at zero.
  - RUN: prescaler counts.
  - PAUSED: prescaler and elapsedMili hold.
- Control priority per cycle: clear > stop > start. Lap is evaluated independently.
- Transitions:
  - clear in any state -> IDLE next cycle; elapsedMili, lapMili and prescaler all set to 0.
  - stop in RUN -> PAUSED. stop in IDLE or PAUSED has no effect.
  - start in IDLE or PAUSED -> RUN. start in RUN has no effect.
- Prescaler (RUN only):
  - counts 0..DIV-1.
  - on the cycle it equals DIV-1: it wraps to 0, elapsedMili increments by 1 on that edge, and tickMs is high for that cycle.
  - in PAUSED it holds its value, so resuming does not lose the partial millisecond.
- First increment after a start from IDLE occurs exactly DIV cycles after running goes high.
- A stop asserted in the same cycle as a tick: the increment for that tick still occurs, then the state becomes PAUSED.
- running is registered and equals (state==RUN).
- lap:
  - in RUN or PAUSED with clear low: lapMili <= current registered elapsedMili (pre-increment value if a tick coincides). lapValid is high the next cycle for exactly one cycle.
  - in IDLE, or when clear is high: ignored.
- Holding lap high recaptures and re-pulses lapValid every cycle; edge detection is the caller's job.
- Counter overflow: elapsedMili wraps to 0 modulo 2^MS_WIDTH when DAY_WRAP_EN is not defined.
- Outputs are registered; no combinational input-to-output path.

Optional Feature:
Macro: MILI_STOPWATCH_DAY_WRAP_EN.
- Defined:
  - elapsedMili wraps from 86399999 to 0 on the next tick, so the converter never sees 24 h or more.
  - Adds output dayRollover (1 bit, reset 0), pulsed for the single cycle of that wrapping tick.
  - Lap snapshots follow the same wrapped value.
- Not defined: no dayRollover port. Wrap occurs only at 2^MS_WIDTH.

Test Plan:
All scenarios use CLK_FREQ_HZ=4000, giving DIV=4.
1. Reset with rst_n low mid-RUN -> all outputs 0 immediately (asynchronous), state IDLE. After release, no tickMs until a start.
2. start for one cycle, run 40 cycles -> running=1, tickMs pulses every 4th cycle, elapsedMili=10.
3. Pause/resume: RUN for 6 cycles (elapsedMili=1, prescaler=2), stop for 20 cycles, then start -> elapsedMili stays 1 while paused. It reaches 2 exactly 2 cycles after running returns high.
4. lap asserted on a tick cycle when elapsedMili=5 -> lapMili=5, lapValid high 1 cycle, elapsedMili=6. Then clear and start together -> IDLE, all zero, start ignored.
5. start and stop asserted in the same cycle from IDLE -> stays IDLE. stop asserted on a tick cycle in RUN -> increment happens, running drops.
6. DAY_WRAP_EN defined, elapsedMili preloaded via force to 86399999, in RUN -> next tick gives elapsedMili=0 and dayRollover=1 for one cycle. Without the macro, the next value is 86400000.
